mmap_rx_fifo: RTL and testbench
===============================

Name: mmap_rx_fifo

Overview:
- Parametrised successor of the SPI-to-mmap byte buffer.
- Sits between spi_slave (dout/done) and mmap_protocol (rx_data/new_rx_data/busy).
- Stores bytes in a power-of-two FIFO and issues them to the protocol only when it is not busy.
- Adds configurable width and depth, hysteresis-based almost-full flow control for the host busy pin, a fill level output, and optional overflow/peak statistics.

Parameters:
- DATA_W, 8: word width.
- DEPTH_LOG2, 6: FIFO depth = 2^DEPTH_LOG2 entries.
- AF_HI, 48: almost_full sets when level >= AF_HI.
- AF_LO, 16: almost_full clears when level <= AF_LO. Requires AF_LO < AF_HI <= depth.
- GAP, 1: cycles mp_busy is ignored after each issue strobe, to cover consumer busy latency. Must be >= 1.
- OVF_CNT_W, 16: width of the overflow counter.

Ports:
- clk  in  1  system clock (16 MHz domain); the only clock.
- rst  in  1  reset, synchronous, active-low.
- rx_data  in  DATA_W  word from SPI slave.
- new_rx_data  in  1  one-cycle write strobe.
- mp_busy  in  1  consumer busy.
- mp_rx_data  out  DATA_W  issued word.
- mp_new_rx_data  out  1  one-cycle issue strobe.
- overflow  out  1  one-cycle pulse when a write is dropped.
- clear  out  1  FIFO empty and no issue in progress.
- mb_full  out  1  level == 2^DEPTH_LOG2.
- almost_full  out  1  hysteresis flow-control flag.
- level  out  DEPTH_LOG2+1  current occupancy.
- ovf_count  out  OVF_CNT_W  saturating dropped-word count.
- peak_level  out  DEPTH_LOG2+1  highest level since reset.

Behaviour:
- Reset (rst low at a clk edge): pointers and level 0; state IDLE; hold counter 0.
  - Outputs after reset: mp_rx_data 0, mp_new_rx_data 0, overflow 0, mb_full 0, almost_full 0, ovf_count 0, peak_level 0, clear 1.
  - Reset mid-operation discards all stored words and any pending hold.
- Storage: 2^DEPTH_LOG2 x DATA_W array. Write and read pointers are DEPTH_LOG2 bits and wrap modulo depth. level holds full-count width.
- Write: on an edge with new_rx_data=1:
  - If level (pre-edge) < depth: store rx_data at wptr, wptr+1.
  - Otherwise: drop the word, pulse overflow for exactly one cycle, leave pointers unchanged.
  - A write when full is dropped even if a pop occurs on the same edge; fullness is judged on the registered level.
- Issue FSM:
  - IDLE: if level != 0 and mp_busy == 0, then on the edge: mp_rx_data <= mem[rptr], mp_new_rx_data <= 1, rptr+1, go HOLD with hold counter = GAP.
  - HOLD: mp_new_rx_data <= 0. mp_busy is ignored. Decrement the hold counter; return to IDLE when it reaches 0 (GAP cycles in HOLD).
  - mp_new_rx_data is high for exactly one cycle per issued word. mp_rx_data holds its value until the next issue.
- Latency and throughput:
  - A word written on edge k (FIFO empty, consumer idle, FSM in IDLE) is strobed out in the cycle after edge k+1.
  - Maximum issue rate is one word per GAP+1 cycles.
- Level:
  - Push only: +1. Pop only: -1. Push and pop on the same edge: unchanged.
  - Never negative; never exceeds depth.
- almost_full:
  - Set when level >= AF_HI. Cleared when level <= AF_LO. Otherwise holds.
  - Registered, evaluated on the updated level, so it changes on the same edge as level.
- mb_full = (level == depth), registered alongside level.
- clear = (level == 0) && state == IDLE && !mp_new_rx_data. Combinational from registers. Top level drives the host busy pin from clear && !almost_full.
- Ordering: strict FIFO; no word is duplicated or reordered across pointer wrap.

Optional Feature:
- Macro: MMAP_RX_FIFO_STATS_EN.
- Defined:
  - ovf_count increments on each dropped word and saturates at all-ones.
  - peak_level tracks max(level) since reset.
- Undefined:
  - ovf_count and peak_level tied to 0; no counter logic synthesised.
  - overflow pulse and all other behaviour unchanged.

Test Plan:
- Reset: hold rst=0 for 3 cycles, release -> clear=1, level=0, all strobes 0, ovf_count=0.
- Single word: mp_busy=0, write 8'hA5 on edge k -> mp_new_rx_data=1 with mp_rx_data=8'hA5 in the cycle after edge k+1 only; then clear=1 once HOLD ends.
- Back-pressure and wrap: mp_busy=1, write 64 words 0..63 -> mb_full=1, almost_full=1 (set at level 48).
  - 65th write (8'hFF) -> overflow pulse, level stays 64, ovf_count=1 (stats enabled).
  - Release mp_busy -> 0..63 issued in order, 2 cycles apart (GAP=1).
  - almost_full clears when level reaches 16.
- Simultaneous push/pop: level=5 with continuous writes each cycle while draining -> level rises by exactly 1 every 2 cycles (push every cycle, pop every other); no loss.
- Busy mid-stream: assert mp_busy during HOLD -> no new strobe until mp_busy falls; the next strobe follows 1 cycle after mp_busy low in IDLE.
- Reset mid-drain: rst=0 with level=10 -> next cycle level=0, clear=1, no further strobes; peak_level=0.

Source files
------------

// File: rtl/mmap_rx_fifo_if.sv
// Bundled bus between the SPI-side writer, the mmap_protocol consumer and the
// status observers of mmap_rx_fifo.
interface mmap_rx_fifo_if #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 6,
  parameter int OVF_CNT_W  = 16
);
  logic [DATA_W-1:0]     rx_data;
  logic                  new_rx_data;
  logic                  mp_busy;
  logic [DATA_W-1:0]     mp_rx_data;
  logic                  mp_new_rx_data;
  logic                  overflow;
  logic                  clear;
  logic                  mb_full;
  logic                  almost_full;
  logic [DEPTH_LOG2:0]   level;
  logic [OVF_CNT_W-1:0]  ovf_count;
  logic [DEPTH_LOG2:0]   peak_level;

  modport slave (
    input  rx_data, new_rx_data, mp_busy,
    output mp_rx_data, mp_new_rx_data, overflow, clear, mb_full,
           almost_full, level, ovf_count, peak_level
  );

  modport master (
    output rx_data, new_rx_data, mp_busy,
    input  mp_rx_data, mp_new_rx_data, overflow, clear, mb_full,
           almost_full, level, ovf_count, peak_level
  );
endinterface

// File: rtl/mmap_rx_fifo.sv
// SPI-to-mmap receive FIFO with paced issue FSM and hysteresis almost-full flag.
// Define MMAP_RX_FIFO_STATS_EN to build the overflow counter and peak-level tracker.
//
// state  | meaning
// S_IDLE | may issue the head word when the FIFO is non-empty and consumer not busy
// S_HOLD | issue just made; mp_busy ignored for GAP cycles
module mmap_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 6,
  parameter int AF_HI      = 48,
  parameter int AF_LO      = 16,
  parameter int GAP        = 1,
  parameter int OVF_CNT_W  = 16
) (
  input  logic          clk,
  input  logic          rst,
  mmap_rx_fifo_if.slave fifo
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int LVL_W  = DEPTH_LOG2 + 1;
  localparam int HOLD_W = (GAP < 2) ? 1 : $clog2(GAP + 1);

  localparam logic [LVL_W-1:0]  DEPTH_L = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]  AF_HI_L = LVL_W'(AF_HI);
  localparam logic [LVL_W-1:0]  AF_LO_L = LVL_W'(AF_LO);
  localparam logic [HOLD_W-1:0] GAP_L   = HOLD_W'(GAP);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  strobe_q, strobe_d;
  logic                  ovf_q, ovf_d;
  logic                  af_q, af_d;
  logic                  full_q, full_d;

  logic push;
  logic pop;

  // Fullness is judged on the registered level, so a pop on the same edge
  // never rescues a write arriving while full.
  assign push = fifo.new_rx_data && (level_q != DEPTH_L);
  assign pop  = (state_q == S_IDLE) && (level_q != '0) && !fifo.mp_busy;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    rptr_d   = rptr_q;
    rdata_d  = rdata_q;
    strobe_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          rdata_d  = mem[rptr_q];
          strobe_d = 1'b1;
          rptr_d   = rptr_q + DEPTH_LOG2'(1);
          hold_d   = GAP_L;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        hold_d = hold_q - HOLD_W'(1);
        if (hold_q == HOLD_W'(1)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wptr_d = push ? (wptr_q + DEPTH_LOG2'(1)) : wptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    ovf_d = fifo.new_rx_data && !push;
    // Hysteresis band: between AF_LO and AF_HI the flag keeps its last value.
    if (level_d >= AF_HI_L) begin
      af_d = 1'b1;
    end else if (level_d <= AF_LO_L) begin
      af_d = 1'b0;
    end else begin
      af_d = af_q;
    end
    full_d = (level_d == DEPTH_L);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      hold_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      rdata_q  <= '0;
      strobe_q <= 1'b0;
      ovf_q    <= 1'b0;
      af_q     <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      rdata_q  <= rdata_d;
      strobe_q <= strobe_d;
      ovf_q    <= ovf_d;
      af_q     <= af_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem[wptr_q] <= fifo.rx_data;
    end
  end

`ifdef MMAP_RX_FIFO_STATS_EN
  logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [LVL_W-1:0]     peak_q, peak_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_d && (ovf_cnt_q != '1)) begin
      ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
    end
    peak_d = (level_d > peak_q) ? level_d : peak_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_cnt_q <= '0;
      peak_q    <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
      peak_q    <= peak_d;
    end
  end

  assign fifo.ovf_count  = ovf_cnt_q;
  assign fifo.peak_level = peak_q;
`else
  assign fifo.ovf_count  = '0;
  assign fifo.peak_level = '0;
`endif

  assign fifo.mp_rx_data     = rdata_q;
  assign fifo.mp_new_rx_data = strobe_q;
  assign fifo.overflow       = ovf_q;
  assign fifo.mb_full        = full_q;
  assign fifo.almost_full    = af_q;
  assign fifo.level          = level_q;
  assign fifo.clear          = (level_q == '0) && (state_q == S_IDLE) && !strobe_q;

endmodule

// File: tb/tb_mmap_rx_fifo.sv
// Bench for mmap_rx_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mmap_rx_fifo;
  localparam int DATA_W     = 8;
  localparam int DEPTH_LOG2 = 6;
  localparam int AF_HI      = 48;
  localparam int AF_LO      = 16;
  localparam int GAP        = 1;
  localparam int OVF_CNT_W  = 16;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mmap_rx_fifo_if #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .OVF_CNT_W(OVF_CNT_W)) bus ();

  mmap_rx_fifo #(
    .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .AF_HI(AF_HI), .AF_LO(AF_LO),
    .GAP(GAP), .OVF_CNT_W(OVF_CNT_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .fifo (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] q[$];
  int    cyc      = 0;
  int    last_iss = -1000;
  bit    m_valid  = 0;
  bit    e_strobe, e_ovf, e_af, e_full, e_clear;
  logic [DATA_W-1:0] e_data;
  int    e_ovf_cnt, e_peak;

  initial begin
    logic r, w, b, drop, iss;
    logic [DATA_W-1:0] d;
    forever begin
      @(posedge clk);
      r = rst; w = bus.new_rx_data; b = bus.mp_busy; d = bus.rx_data;
      cyc++;
      if (!r) begin
        q.delete();
        last_iss = -1000;
        e_strobe = 0; e_ovf = 0; e_af = 0; e_full = 0;
        e_data = '0; e_ovf_cnt = 0; e_peak = 0;
        m_valid = 1;
      end else begin
        drop = w && (q.size() == DEPTH);
        iss  = (q.size() != 0) && !b && (cyc - last_iss > GAP);
        e_strobe = iss;
        if (iss) begin
          e_data   = q.pop_front();
          last_iss = cyc;
        end
        if (w && !drop) q.push_back(d);
        e_ovf = drop;
        if (drop && e_ovf_cnt != (1 << OVF_CNT_W) - 1) e_ovf_cnt++;
        if (q.size() >= AF_HI) e_af = 1;
        else if (q.size() <= AF_LO) e_af = 0;
        e_full = (q.size() == DEPTH);
        if (q.size() > e_peak) e_peak = q.size();
      end
      e_clear = (q.size() == 0) && (cyc - last_iss >= GAP) && !e_strobe;
      #1;
      if (m_valid) begin
        check("m_strobe",  32'(bus.mp_new_rx_data), 32'(e_strobe));
        check("m_data",    32'(bus.mp_rx_data),     32'(e_data));
        check("m_ovf",     32'(bus.overflow),       32'(e_ovf));
        check("m_clear",   32'(bus.clear),          32'(e_clear));
        check("m_full",    32'(bus.mb_full),        32'(e_full));
        check("m_af",      32'(bus.almost_full),    32'(e_af));
        check("m_level",   32'(bus.level),          32'(q.size()));
`ifdef MMAP_RX_FIFO_STATS_EN
        check("m_ovf_cnt", 32'(bus.ovf_count),      32'(e_ovf_cnt));
        check("m_peak",    32'(bus.peak_level),     32'(e_peak));
`else
        check("m_ovf_cnt", 32'(bus.ovf_count),      32'd0);
        check("m_peak",    32'(bus.peak_level),     32'd0);
`endif
      end
    end
  end

  // ---------------- stimulus + directed literal checks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int idx, last_t, nstr, t, pw, pb;
    bus.rx_data = '0; bus.new_rx_data = 1'b0; bus.mp_busy = 1'b0;
    rst = 1'b0;

    // reset
    repeat (3) tick();
    rst = 1'b1;
    check("rst_clear",  32'(bus.clear), 32'd1);
    check("rst_level",  32'(bus.level), 32'd0);
    check("rst_strobe", 32'(bus.mp_new_rx_data), 32'd0);
    check("rst_ovfcnt", 32'(bus.ovf_count), 32'd0);
    check("rst_peak",   32'(bus.peak_level), 32'd0);

    // single word latency
    tick();
    bus.rx_data = 8'hA5; bus.new_rx_data = 1'b1;
    tick();
    bus.new_rx_data = 1'b0;
    check("single_k_strobe", 32'(bus.mp_new_rx_data), 32'd0);
    check("single_k_level",  32'(bus.level), 32'd1);
    tick();
    check("single_k1_strobe", 32'(bus.mp_new_rx_data), 32'd1);
    check("single_k1_data",   32'(bus.mp_rx_data), 32'hA5);
    tick();
    check("single_k2_strobe", 32'(bus.mp_new_rx_data), 32'd0);
    check("single_k2_clear",  32'(bus.clear), 32'd1);
    check("single_k2_hold",   32'(bus.mp_rx_data), 32'hA5);

    // back-pressure fill to full
    bus.mp_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.rx_data = DATA_W'(i); bus.new_rx_data = 1'b1;
      tick();
      if (i == AF_HI - 2) check("af_below_hi", 32'(bus.almost_full), 32'd0);
      if (i == AF_HI - 1) check("af_at_hi",    32'(bus.almost_full), 32'd1);
    end
    check("fill_full",  32'(bus.mb_full), 32'd1);
    check("fill_level", 32'(bus.level), 32'd64);
    bus.rx_data = 8'hFF;
    tick();
    bus.new_rx_data = 1'b0;
    check("ovf_pulse", 32'(bus.overflow), 32'd1);
    check("ovf_level", 32'(bus.level), 32'd64);
`ifdef MMAP_RX_FIFO_STATS_EN
    check("ovf_count", 32'(bus.ovf_count), 32'd1);
    check("peak_full", 32'(bus.peak_level), 32'd64);
`else
    check("ovf_count", 32'(bus.ovf_count), 32'd0);
`endif
    tick();
    check("ovf_one_cycle", 32'(bus.overflow), 32'd0);

    // drain in order, GAP+1 apart
    bus.mp_busy = 1'b0;
    idx = 0; last_t = 0;
    for (t = 1; t <= 300 && idx < DEPTH; t++) begin
      tick();
      if (bus.level == 17) check("af_hold_17", 32'(bus.almost_full), 32'd1);
      if (bus.level == 16) check("af_clear_16", 32'(bus.almost_full), 32'd0);
      if (bus.mp_new_rx_data) begin
        check("drain_data", 32'(bus.mp_rx_data), 32'(idx));
        if (idx > 0) check("drain_gap", 32'(t - last_t), 32'(GAP + 1));
        last_t = t;
        idx++;
      end
    end
    check("drain_count", 32'(idx), 32'(DEPTH));

    // simultaneous push/pop from level 5
    bus.mp_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.rx_data = DATA_W'($urandom); bus.new_rx_data = 1'b1;
      tick();
    end
    check("pp_start_level", 32'(bus.level), 32'd5);
    bus.mp_busy = 1'b0;
    nstr = 0;
    for (int i = 0; i < 20; i++) begin
      bus.rx_data = DATA_W'($urandom);
      tick();
      if (bus.mp_new_rx_data) nstr++;
    end
    bus.new_rx_data = 1'b0;
    check("pp_level", 32'(bus.level), 32'd15);
    check("pp_pops",  32'(nstr), 32'd10);

    // busy asserted during HOLD
    idx = 0;
    for (int i = 0; i < 10 && !bus.mp_new_rx_data; i++) begin
      tick();
      idx++;
    end
    check("bm_found_strobe", 32'(bus.mp_new_rx_data), 32'd1);
    bus.mp_busy = 1'b1;
    nstr = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.mp_new_rx_data) nstr++;
    end
    check("bm_no_strobe", 32'(nstr), 32'd0);
    bus.mp_busy = 1'b0;
    tick();
    check("bm_resume", 32'(bus.mp_new_rx_data), 32'd1);

    // reset mid-operation with level 10
    rst = 1'b0; tick(); rst = 1'b1;
    bus.mp_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.rx_data = DATA_W'($urandom); bus.new_rx_data = 1'b1;
      tick();
    end
    bus.new_rx_data = 1'b0;
    check("rm_level10", 32'(bus.level), 32'd10);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rm_level", 32'(bus.level), 32'd0);
    check("rm_clear", 32'(bus.clear), 32'd1);
    check("rm_peak",  32'(bus.peak_level), 32'd0);
    bus.mp_busy = 1'b0;
    nstr = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.mp_new_rx_data) nstr++;
    end
    check("rm_no_strobe", 32'(nstr), 32'd0);

    // randomized traffic, model-checked every cycle
    pw = 50; pb = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        pw = $urandom_range(95, 10);
        pb = $urandom_range(90, 0);
      end
      bus.rx_data     = DATA_W'($urandom);
      bus.new_rx_data = ($urandom_range(99, 0) < pw);
      bus.mp_busy     = ($urandom_range(99, 0) < pb);
      rst             = ($urandom_range(499, 0) != 0);
      tick();
    end
    rst = 1'b1; bus.new_rx_data = 1'b0; bus.mp_busy = 1'b0;
    repeat (200) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end
endmodule
